// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving a generic synchronous dual-port RAM.
// The RAM output register doubles as the head-of-queue slot, so capacity is 2^aw + 1 words.
module dpram_fifo_ctrl #(
  parameter int aw = 5,
  parameter int dw = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [dw-1:0] din,
  output logic          full,
  input  logic          pop,
  output logic [dw-1:0] dout,
  output logic          empty,
  output logic [aw:0]   count,
  output logic          wr_err,
  output logic          rd_err,
  output logic          ram_wce,
  output logic          ram_we,
  output logic [aw-1:0] ram_waddr,
  output logic [dw-1:0] ram_di,
  output logic          ram_rce,
  output logic          ram_oe,
  output logic [aw-1:0] ram_raddr,
  input  logic [dw-1:0] ram_do
);

  localparam logic [aw:0] DEPTH = {1'b1, {aw{1'b0}}};
  localparam logic [aw:0] ONE   = {{aw{1'b0}}, 1'b1};

  logic [aw:0] wptr;
  logic [aw:0] rptr;
  logic [aw:0] ram_cnt;
  logic        hv;
  logic        wr_ok;
  logic        rd_ok;
  logic        rd_issue;

  // Equal RAM addresses only occur at ram_cnt 0 (no read) or 2^aw (no write),
  // so a write and a read never collide on one address.
  always_comb begin
    ram_cnt  = wptr - rptr;
    full     = (ram_cnt == DEPTH);
    empty    = !hv;
    count    = ram_cnt + {{aw{1'b0}}, hv};
    wr_ok    = push & !full & !rst;
    rd_ok    = pop & hv;
    rd_issue = (ram_cnt != '0) & (!hv | rd_ok) & !rst;
  end

  assign ram_wce   = wr_ok;
  assign ram_we    = wr_ok;
  assign ram_waddr = wptr[aw-1:0];
  assign ram_di    = din;
  assign ram_rce   = rd_issue;
  assign ram_oe    = 1'b1;
  assign ram_raddr = rptr[aw-1:0];
  assign dout      = ram_do;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      hv     <= 1'b0;
      wr_err <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      wr_err <= push & full;
      rd_err <= pop & !hv;
      if (wr_ok)
        wptr <= wptr + ONE;
      if (rd_issue) begin
        rptr <= rptr + ONE;
        hv   <= 1'b1;
      end else if (rd_ok) begin
        hv   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed-vector and scoreboard bench for dpram_fifo_ctrl (aw=2, dw=8) with a behavioural RAM.
module tb_dpram_fifo_ctrl;

  localparam int AW = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic [DW-1:0] din;
  logic          full;
  logic          pop;
  logic [DW-1:0] dout;
  logic          empty;
  logic [AW:0]   count;
  logic          wr_err;
  logic          rd_err;
  logic          ram_wce;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_di;
  logic          ram_rce;
  logic          ram_oe;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_do;

  logic [DW-1:0] mem [1<<AW];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(.aw(AW), .dw(DW)) dut (
    .clk(clk), .rst(rst), .push(push), .din(din), .full(full), .pop(pop),
    .dout(dout), .empty(empty), .count(count), .wr_err(wr_err), .rd_err(rd_err),
    .ram_wce(ram_wce), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_di(ram_di),
    .ram_rce(ram_rce), .ram_oe(ram_oe), .ram_raddr(ram_raddr), .ram_do(ram_do)
  );

  // Generic synchronous dual-port RAM: registered read, holds while read-CE is low.
  always @(posedge clk) begin
    if (ram_wce && ram_we)
      mem[ram_waddr] <= ram_di;
    if (ram_rce)
      ram_do <= mem[ram_raddr];
  end

  typedef struct {
    logic          push;
    logic          pop;
    logic [DW-1:0] din;
    logic          e_empty;
    logic          e_full;
    logic [AW:0]   e_count;
    logic          chk_dout;
    logic [DW-1:0] e_dout;
    logic          e_wr_err;
    logic          e_rd_err;
  } vec_t;

  vec_t tbl[$];
  logic [DW-1:0] model[$];

  function automatic vec_t mk(input logic p, input logic q, input logic [7:0] d,
                              input logic ee, input logic ef, input logic [2:0] ec,
                              input logic cd, input logic [7:0] ed,
                              input logic ew, input logic er);
    vec_t v;
    v.push = p; v.pop = q; v.din = d;
    v.e_empty = ee; v.e_full = ef; v.e_count = ec;
    v.chk_dout = cd; v.e_dout = ed; v.e_wr_err = ew; v.e_rd_err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_comb();
    tests++;
    if (ram_we && ram_rce && (ram_waddr == ram_raddr)) begin
      fails++;
      $display("FAIL collision: waddr %0h raddr %0h at %0t", ram_waddr, ram_raddr, $time);
    end
    if (!empty && $isunknown(dout)) begin
      tests++;
      fails++;
      $display("FAIL dout_x: dout unknown while not empty at %0t", $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic cyc(input logic p, input logic q, input logic [DW-1:0] d);
    push = p; pop = q; din = d;
    #1;
    chk_comb();
    @(posedge clk); #1;
  endtask

  task automatic sb_cycle(input logic p, input logic q, input logic [DW-1:0] d);
    logic [DW-1:0] exp;
    push = p; pop = q; din = d;
    #1;
    chk_comb();
    if (q && !empty) begin
      if (model.size() == 0) begin
        chk("sb_underflow", 32'(model.size()), 32'd1);
      end else begin
        exp = model.pop_front();
        chk("sb_dout", 32'(dout), 32'(exp));
      end
    end
    if (p && !full)
      model.push_back(d);
    @(posedge clk); #1;
    chk("sb_count", 32'(count), 32'(model.size()));
    if (model.size() == 0)
      chk("sb_empty", 32'(empty), 32'd1);
    if (model.size() == 5)
      chk("sb_full", 32'(full), 32'd1);
  endtask

  initial begin
    int popped;
    rst = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_rd_err", 32'(rd_err), 32'd0);
    chk("ram_oe", 32'(ram_oe), 32'd1);

    // push, pop, din | empty, full, count | chk_dout, dout | wr_err, rd_err
    tbl.push_back(mk(1,0,8'hA1, 1,0,1, 0,8'h00, 0,0));
    tbl.push_back(mk(0,0,8'h00, 0,0,1, 1,8'hA1, 0,0));
    tbl.push_back(mk(0,1,8'h00, 1,0,0, 0,8'h00, 0,0));
    tbl.push_back(mk(1,0,8'h10, 1,0,1, 0,8'h00, 0,0));
    tbl.push_back(mk(1,0,8'h11, 0,0,2, 1,8'h10, 0,0));
    tbl.push_back(mk(1,0,8'h12, 0,0,3, 1,8'h10, 0,0));
    tbl.push_back(mk(1,0,8'h13, 0,0,4, 1,8'h10, 0,0));
    tbl.push_back(mk(1,0,8'h14, 0,1,5, 1,8'h10, 0,0));
    tbl.push_back(mk(1,0,8'h15, 0,1,5, 1,8'h10, 1,0));
    tbl.push_back(mk(0,0,8'h00, 0,1,5, 1,8'h10, 0,0));
    tbl.push_back(mk(0,1,8'h00, 0,0,4, 1,8'h11, 0,0));
    tbl.push_back(mk(0,1,8'h00, 0,0,3, 1,8'h12, 0,0));
    tbl.push_back(mk(0,1,8'h00, 0,0,2, 1,8'h13, 0,0));
    tbl.push_back(mk(0,1,8'h00, 0,0,1, 1,8'h14, 0,0));
    tbl.push_back(mk(0,1,8'h00, 1,0,0, 0,8'h00, 0,0));
    tbl.push_back(mk(0,1,8'h00, 1,0,0, 0,8'h00, 0,1));
    tbl.push_back(mk(0,0,8'h00, 1,0,0, 0,8'h00, 0,0));
    tbl.push_back(mk(1,0,8'h20, 1,0,1, 0,8'h00, 0,0));
    tbl.push_back(mk(1,0,8'h21, 0,0,2, 1,8'h20, 0,0));
    tbl.push_back(mk(1,0,8'h22, 0,0,3, 1,8'h20, 0,0));
    tbl.push_back(mk(1,0,8'h23, 0,0,4, 1,8'h20, 0,0));
    tbl.push_back(mk(1,0,8'h24, 0,1,5, 1,8'h20, 0,0));
    tbl.push_back(mk(1,1,8'h25, 0,0,4, 1,8'h21, 1,0));
    tbl.push_back(mk(0,0,8'h00, 0,0,4, 1,8'h21, 0,0));

    foreach (tbl[i]) begin
      cyc(tbl[i].push, tbl[i].pop, tbl[i].din);
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].e_full));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_count));
      chk($sformatf("v%0d_wr_err", i), 32'(wr_err), 32'(tbl[i].e_wr_err));
      chk($sformatf("v%0d_rd_err", i), 32'(rd_err), 32'(tbl[i].e_rd_err));
      if (tbl[i].chk_dout)
        chk($sformatf("v%0d_dout", i), 32'(dout), 32'(tbl[i].e_dout));
    end

    // Reset with push and pop asserted: nothing may reach the RAM.
    do_reset();
    cyc(1'b1, 1'b0, 8'h31);
    cyc(1'b1, 1'b0, 8'h32);
    cyc(1'b1, 1'b0, 8'h33);
    chk("fill3_count", 32'(count), 32'd3);
    rst = 1'b1; push = 1'b1; pop = 1'b1; din = 8'h77;
    #1;
    chk("rstcyc_we", 32'(ram_we), 32'd0);
    chk("rstcyc_wce", 32'(ram_wce), 32'd0);
    chk("rstcyc_rce", 32'(ram_rce), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_full", 32'(full), 32'd0);
    chk("midrst_wr_err", 32'(wr_err), 32'd0);
    push = 1'b1; pop = 1'b0; din = 8'hAA;
    #1;
    chk("aa_waddr", 32'(ram_waddr), 32'd0);
    chk("aa_we", 32'(ram_we), 32'd1);
    chk("aa_di", 32'(ram_di), 32'hAA);
    @(posedge clk); #1;
    push = 1'b0;
    chk("aa_lat1_empty", 32'(empty), 32'd1);
    @(posedge clk); #1;
    chk("aa_lat2_empty", 32'(empty), 32'd0);
    chk("aa_lat2_dout", 32'(dout), 32'hAA);

    // Streaming push+pop every cycle across several pointer wraps.
    do_reset();
    model.delete();
    popped = 0;
    for (int i = 0; i < 40; i++) begin
      push = 1'b1; pop = 1'b1; din = 8'(8'h40 + i);
      #1;
      if (i >= 2)
        chk("stream_nogap", 32'(empty), 32'd0);
      if (!empty)
        popped++;
      sb_cycle(1'b1, 1'b1, 8'(8'h40 + i));
      if (i >= 1)
        chk("stream_count_1_2", 32'((count == 1) || (count == 2)), 32'd1);
    end
    chk("stream_popped", 32'(popped), 32'd38);

    // Random traffic with alternating fill/drain bias.
    do_reset();
    model.delete();
    for (int i = 0; i < 2000; i++) begin
      logic p, q;
      if (((i / 100) % 2) == 0) begin
        p = ($urandom_range(0, 3) != 0);
        q = ($urandom_range(0, 3) == 0);
      end else begin
        p = ($urandom_range(0, 3) == 0);
        q = ($urandom_range(0, 3) != 0);
      end
      sb_cycle(p, q, 8'($urandom_range(0, 255)));
    end

    push = 1'b0; pop = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
